// File: rtl/taxi_apb_arb_rr_if.sv
// Signal bundle for the round-robin APB arbiter: the PORTS requester-side
// APB slave ports plus the single shared APB master port.
// The master modport is the arbiter's view; the slave modport is the
// environment's view (requesters and completer).
interface taxi_apb_arb_rr_if #(
    parameter int PORTS  = 3,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int STRB_W = DATA_W/8
);
    // Requester side
    logic [PORTS-1:0]        s_psel;
    logic [PORTS-1:0]        s_penable;
    logic [PORTS-1:0]        s_pwrite;
    logic [PORTS*ADDR_W-1:0] s_paddr;
    logic [PORTS*DATA_W-1:0] s_pwdata;
    logic [PORTS*STRB_W-1:0] s_pstrb;
    logic [PORTS-1:0]        s_pready;
    logic [DATA_W-1:0]       s_prdata;
    logic [PORTS-1:0]        s_pslverr;

    // Completer side
    logic                    m_psel;
    logic                    m_penable;
    logic                    m_pwrite;
    logic [ADDR_W-1:0]       m_paddr;
    logic [DATA_W-1:0]       m_pwdata;
    logic [STRB_W-1:0]       m_pstrb;
    logic                    m_pready;
    logic [DATA_W-1:0]       m_prdata;
    logic                    m_pslverr;

    modport master (
        input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
        output s_pready, s_prdata, s_pslverr,
        output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb,
        input  m_pready, m_prdata, m_pslverr
    );

    modport slave (
        output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
        input  s_pready, s_prdata, s_pslverr,
        input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb,
        output m_pready, m_prdata, m_pslverr
    );
endinterface

// File: rtl/taxi_apb_arb_rr.sv
// Round-robin arbiter sharing one APB master port between PORTS requesters.
// Transfers are serialised through IDLE -> SETUP -> ACCESS -> RESP; all
// master-side outputs are registered and the response is steered back to
// the granted requester only.
// Optional hung-transfer abort: define APB_ARB_TIMEOUT_EN to terminate an
// ACCESS phase with an error after TIMEOUT_CYCLES cycles without m_pready.
module taxi_apb_arb_rr #(
    parameter int PORTS          = 3,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int STRB_W         = DATA_W/8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int GRANT_W       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    taxi_apb_arb_rr_if.master  bus,
    output logic [GRANT_W-1:0] grant,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic [GRANT_W-1:0] ptr;
    logic [GRANT_W-1:0] pick;
    logic               pick_valid;
    int                 idx;
    logic [DATA_W-1:0]  resp_data;
    logic               resp_err;
    logic               abort;
    logic [PORTS-1:0]   resp_onehot;

    // s_penable carries no information the arbiter needs
    logic unused_penable;
    assign unused_penable = ^bus.s_penable;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Count stalled ACCESS cycles; zero whenever not in ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state != ACCESS) begin
            to_cnt <= '0;
        end else if (!bus.m_pready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Limit hit on the last allowed stalled cycle; a late m_pready still wins
    assign abort = (state == ACCESS) && !bus.m_pready &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign abort = 1'b0;
`endif

    // Rotating-priority search starting at ptr
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= PORTS) begin
                idx = idx - PORTS;
            end
            if (!pick_valid && bus.s_psel[idx]) begin
                pick_valid = 1'b1;
                pick       = GRANT_W'(idx);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (bus.m_pready || abort) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered master outputs, grant/pointer update and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_psel    <= 1'b0;
            bus.m_penable <= 1'b0;
            bus.m_pwrite  <= 1'b0;
            bus.m_paddr   <= '0;
            bus.m_pwdata  <= '0;
            bus.m_pstrb   <= '0;
            grant         <= '0;
            ptr           <= '0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
        end else begin
            bus.m_psel    <= (state_next == SETUP) || (state_next == ACCESS);
            bus.m_penable <= (state_next == ACCESS);
            if (state == IDLE && pick_valid) begin
                bus.m_pwrite <= bus.s_pwrite[pick];
                bus.m_paddr  <= bus.s_paddr[pick*ADDR_W +: ADDR_W];
                bus.m_pwdata <= bus.s_pwdata[pick*DATA_W +: DATA_W];
                bus.m_pstrb  <= bus.s_pstrb[pick*STRB_W +: STRB_W];
                grant        <= pick;
                ptr          <= (pick == GRANT_W'(PORTS - 1)) ? '0 : pick + 1'b1;
            end
            if (state == ACCESS && bus.m_pready) begin
                resp_data <= bus.m_prdata;
                resp_err  <= bus.m_pslverr;
            end else if (abort) begin
                resp_data <= '0;
                resp_err  <= 1'b1;
            end
        end
    end

    assign resp_onehot   = (state == RESP) ? (PORTS'(1) << grant) : '0;
    assign bus.s_pready  = resp_onehot;
    assign bus.s_pslverr = resp_err ? resp_onehot : '0;
    assign bus.s_prdata  = resp_data;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_taxi_apb_arb_rr.sv
// Scoreboard bench for taxi_apb_arb_rr: expected transfers are queued in
// expected grant order when requests are driven, and checked when the
// arbiter issues SETUP on the master port and s_pready on the slave side.
// Define APB_ARB_TIMEOUT_EN for both files to exercise the abort path.
module tb_taxi_apb_arb_rr;

    localparam int PORTS          = 3;
    localparam int ADDR_W         = 18;
    localparam int DATA_W         = 16;
    localparam int STRB_W         = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int GRANT_W        = 2;

    typedef struct {
        int                port;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        int                waits;
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                exp_acc;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
        logic              chk_gap;
    } req_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [GRANT_W-1:0] grant;
    logic               busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_len = 0;
    int setup_cyc = 0;
    int last_resp_cyc = 0;
    int bound_cnt;

    req_t exp_q[$];
    req_t port_q[PORTS][$];
    req_t mon_e;

    taxi_apb_arb_rr_if #(.PORTS(PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) bus ();

    taxi_apb_arb_rr #(
        .PORTS(PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .grant(grant),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drivePort(input int p);
        req_t r;
        if (port_q[p].size() > 0) begin
            r = port_q[p][0];
            bus.s_psel[p]                         = 1'b1;
            bus.s_penable[p]                      = 1'b0;
            bus.s_pwrite[p]                       = r.write;
            bus.s_paddr[p*ADDR_W +: ADDR_W]       = r.addr;
            bus.s_pwdata[p*DATA_W +: DATA_W]      = r.wdata;
            bus.s_pstrb[p*STRB_W +: STRB_W]       = r.strb;
        end else begin
            bus.s_psel[p] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int port, input logic write, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                                 input int waits, input logic [DATA_W-1:0] rdata, input logic err,
                                 input logic chk_gap);
        req_t r;
        r.port = port; r.write = write; r.addr = addr; r.wdata = wdata; r.strb = strb;
        r.waits = waits; r.rdata = rdata; r.err = err; r.chk_gap = chk_gap;
        r.exp_acc = waits + 1; r.exp_rdata = rdata; r.exp_err = err;
`ifdef APB_ARB_TIMEOUT_EN
        if (waits >= TIMEOUT_CYCLES) begin
            r.exp_acc = TIMEOUT_CYCLES; r.exp_rdata = '0; r.exp_err = 1'b1;
        end
`endif
        exp_q.push_back(r);
        port_q[port].push_back(r);
        if (port_q[port].size() == 1) drivePort(port);
    endtask

    task automatic waitDrain(input int bound);
        bound_cnt = 0;
        while (exp_q.size() != 0 && bound_cnt < bound) begin
            @(posedge clk);
            bound_cnt++;
        end
        checkOutput("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        exp_q.delete();
        for (int p = 0; p < PORTS; p++) port_q[p].delete();
        bus.s_psel = '0;
        bus.m_pready = 1'b0;
        bus.m_pslverr = 1'b0;
    endtask

    // Completer model, SETUP checker, response checker and requester hand-off
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.m_psel && !bus.m_penable) begin
                acc_len = 0;
                setup_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checkOutput("setup_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q[0];
                    checkOutput("grant", grant, mon_e.port);
                    checkOutput("m_pwrite", bus.m_pwrite, mon_e.write);
                    checkOutput("m_paddr", bus.m_paddr, mon_e.addr);
                    checkOutput("m_pstrb", bus.m_pstrb, mon_e.strb);
                    if (mon_e.write) checkOutput("m_pwdata", bus.m_pwdata, mon_e.wdata);
                end
            end
            if (bus.m_psel && bus.m_penable && exp_q.size() > 0) begin
                acc_len++;
                if (acc_len - 1 == exp_q[0].waits) begin
                    bus.m_pready  = 1'b1;
                    bus.m_prdata  = exp_q[0].rdata;
                    bus.m_pslverr = exp_q[0].err;
                end else begin
                    bus.m_pready  = 1'b0;
                    bus.m_prdata  = DATA_W'($urandom);
                    bus.m_pslverr = 1'b1;
                end
            end else begin
                bus.m_pready  = 1'b0;
                bus.m_prdata  = '0;
                bus.m_pslverr = 1'b0;
            end
            if (bus.s_pready != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("pready_unexpected", bus.s_pready, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("s_pready", bus.s_pready, 1 << mon_e.port);
                    checkOutput("s_pslverr", bus.s_pslverr, mon_e.exp_err ? (1 << mon_e.port) : 0);
                    checkOutput("s_prdata", bus.s_prdata, mon_e.exp_rdata);
                    checkOutput("access_len", acc_len, mon_e.exp_acc);
                    checkOutput("setup_to_resp", cyc - setup_cyc, mon_e.exp_acc + 1);
                    if (mon_e.chk_gap) checkOutput("resp_interval", cyc - last_resp_cyc, 4);
                    last_resp_cyc = cyc;
                    void'(port_q[mon_e.port].pop_front());
                    drivePort(mon_e.port);
                end
            end
        end
    end

    initial begin
        bus.s_psel = '0; bus.s_penable = '0; bus.s_pwrite = '0;
        bus.s_paddr = '0; bus.s_pwdata = '0; bus.s_pstrb = '0;
        bus.m_pready = 1'b0; bus.m_prdata = '0; bus.m_pslverr = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_m_psel", bus.m_psel, 0);
        checkOutput("rst_m_penable", bus.m_penable, 0);
        checkOutput("rst_m_paddr", bus.m_paddr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_s_pready", bus.s_pready, 0);
        checkOutput("rst_s_prdata", bus.s_prdata, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Single zero-wait write from port 1 with explicit latency checks
        @(posedge clk); #2;
        applyStimulus(1, 1'b1, 18'h00123, 16'hBEEF, 2'b11, 0, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("t1_m_psel", bus.m_psel, 1);
        checkOutput("t1_m_penable_lo", bus.m_penable, 0);
        @(posedge clk); #1;
        checkOutput("t1_m_penable_hi", bus.m_penable, 1);
        @(posedge clk); #1;
        checkOutput("t1_s_pready", bus.s_pready, 3'b010);
        checkOutput("t1_s_pslverr", bus.s_pslverr, 0);
        waitDrain(50);

        // Read from port 0 with five wait states
        applyStimulus(0, 1'b0, 18'h2A5A0, 16'h0000, 2'b00, 5, 16'h5A5A, 1'b0, 1'b0);
        waitDrain(50);

        // All ports requesting continuously from reset
        applyReset();
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        applyStimulus(0, 1'b1, 18'h00010, 16'h1000, 2'b01, 0, 16'hA000, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 18'h00011, 16'h1001, 2'b10, 0, 16'hA001, 1'b0, 1'b1);
        applyStimulus(2, 1'b1, 18'h00012, 16'h1002, 2'b11, 0, 16'hA002, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 18'h00020, 16'h2000, 2'b11, 0, 16'hB000, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, 18'h00021, 16'h2001, 2'b01, 0, 16'hB001, 1'b0, 1'b1);
        applyStimulus(2, 1'b0, 18'h00022, 16'h2002, 2'b10, 0, 16'hB002, 1'b0, 1'b1);
        waitDrain(200);

        // Completer error on port 2, then clean transfers on ports 0 and 1
        applyStimulus(2, 1'b1, 18'h3FFFF, 16'hDEAD, 2'b11, 1, 16'hC0DE, 1'b1, 1'b0);
        waitDrain(50);
        applyStimulus(0, 1'b0, 18'h00100, 16'h0000, 2'b00, 0, 16'h0F0F, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 18'h00200, 16'h0000, 2'b00, 2, 16'hF0F0, 1'b0, 1'b0);
        waitDrain(100);

        // Reset asserted during a long ACCESS on port 1
        applyStimulus(1, 1'b1, 18'h01234, 16'h4321, 2'b11, 12, 16'h0000, 1'b0, 1'b0);
        bound_cnt = 0;
        while (!bus.m_penable && bound_cnt < 20) begin
            @(posedge clk);
            bound_cnt++;
        end
        checkOutput("t5_reached_access", bus.m_penable, 1);
        repeat (2) @(posedge clk);
        #2;
        applyReset();
        #1;
        checkOutput("t5_m_psel", bus.m_psel, 0);
        checkOutput("t5_m_penable", bus.m_penable, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_s_pready", bus.s_pready, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        applyStimulus(0, 1'b0, 18'h00300, 16'h0000, 2'b00, 0, 16'h7777, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 18'h00302, 16'h0000, 2'b00, 0, 16'h8888, 1'b0, 1'b1);
        waitDrain(100);

`ifdef APB_ARB_TIMEOUT_EN
        // Completer never ready: abort after the limit
        applyStimulus(0, 1'b0, 18'h00400, 16'h0000, 2'b00, 1000, 16'hDEAD, 1'b0, 1'b0);
        waitDrain(100);
        // Ready on the last allowed ACCESS cycle: normal completion
        applyStimulus(0, 1'b0, 18'h00404, 16'h0000, 2'b00, TIMEOUT_CYCLES - 1, 16'h1234, 1'b0, 1'b0);
        waitDrain(100);
`endif

        checkOutput("final_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
